// File: rtl/fir_mac_ctrl.sv
// Sequencing controller for a signed FIR filter: one shared multiply-accumulate
// stepped across the taps, sample in / result out on valid-ready handshakes.
module fir_mac_ctrl #(
  parameter int TAPS = 3,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int OW   = 18
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  input  logic          coef_we,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          busy
);

  // state | meaning
  // IDLE  | waiting for a sample, coefficient writes allowed
  // MAC   | one tap multiply-accumulate per cycle
  // DONE  | result held on out_data until downstream takes it
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int IW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

  logic [1:0]            state;
  logic signed [DW-1:0]  data [TAPS];
  logic signed [CW-1:0]  coef [TAPS];
  logic signed [OW-1:0]  acc;
  logic [IW-1:0]         idx;
  logic signed [DW+CW-1:0] prod;
  logic signed [OW-1:0]  sum;
  logic                  coef_wr;

  function automatic logic signed [CW-1:0] default_coef(input int k);
    case (k)
      0:       default_coef = CW'(-1);
      1:       default_coef = CW'(2);
      2:       default_coef = CW'(3);
      default: default_coef = '0;
    endcase
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_MAC);

  always_comb begin
    prod = data[idx] * coef[idx];
    sum  = acc + {{(OW-DW-CW){prod[DW+CW-1]}}, prod};
  end

  assign coef_wr = coef_we && !busy && (int'(coef_addr) < TAPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= default_coef(k);
    end else if (coef_wr) begin
      coef[coef_addr[IW-1:0]] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < TAPS; k++) data[k] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) data[k] <= data[k-1];
            data[0] <= in_data;
            acc     <= '0;
            idx     <= '0;
            state   <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= sum;
          idx <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Self-checking bench for fir_mac_ctrl: fixed vector table, hand-written corner
// sequences and randomized samples against a convolution-sum reference model.
module tb_fir_mac_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        busy;

  fir_mac_ctrl #(.TAPS(3), .DW(8), .CW(8), .OW(18)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;
  int mc [3];
  int hist [3];
  int prev_acc = 0;
  int gap = 0;

  typedef struct {
    int x;
    int hold;
    int exp_y;
  } vec_t;
  vec_t tbl [8];

  function automatic void check(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endfunction

  function automatic int s8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  function automatic void model_reset();
    mc[0] = -1; mc[1] = 2; mc[2] = 3;
    for (int k = 0; k < 3; k++) hist[k] = 0;
  endfunction

  // y[n] = sum_k coef[k] * x[n-k], wrapped to the 18-bit output width
  function automatic int model_y();
    int s;
    logic signed [17:0] w;
    s = 0;
    for (int k = 0; k < 3; k++) s += mc[k] * hist[k];
    w = s[17:0];
    return int'(w);
  endfunction

  task automatic write_coef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = addr[2:0]; coef_data = val[7:0];
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < 3) mc[addr] = s8(val);
  endtask

  task automatic do_sample(input int x, input int hold, input bit we, input int waddr,
                           input int wdata, input bit mac_write, output int y);
    int n;
    int lat;
    int exp_v;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_wait", int'(in_ready), 1);
    if (we) begin
      coef_we = 1'b1; coef_addr = waddr[2:0]; coef_data = wdata[7:0];
    end
    in_valid = 1'b1; in_data = x[7:0]; out_ready = 1'b0;
    gap = cyc - prev_acc;
    prev_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0; coef_we = 1'b0;
    if (we && waddr < 3) mc[waddr] = s8(wdata);
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = s8(x);
    exp_v = model_y();
    check("busy_in_mac", int'(busy), 1);
    check("in_ready_in_mac", int'(in_ready), 0);
    if (mac_write) begin
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 8'd77;
    end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      coef_we = 1'b0;
      lat++;
    end
    coef_we = 1'b0;
    check("latency", lat, 3);
    y = int'($signed(out_data));
    check("out_data_model", y, exp_v);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom_range(0, 255));
      @(negedge clk);
      check("bp_out_data_stable", int'($signed(out_data)), exp_v);
      check("bp_in_ready_low", int'(in_ready), 0);
      check("bp_out_valid_high", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("post_hs_out_valid", int'(out_valid), 0);
    check("post_hs_in_ready", int'(in_ready), 1);
    check("post_hs_out_data_held", int'($signed(out_data)), exp_v);
  endtask

  initial begin
    int y;
    int x, hold, waddr, wdata;
    bit we, mw;

    tbl[0] = '{x:   1, hold: 0, exp_y:  -1};
    tbl[1] = '{x:   0, hold: 0, exp_y:   2};
    tbl[2] = '{x:   0, hold: 0, exp_y:   3};
    tbl[3] = '{x:   0, hold: 0, exp_y:   0};
    tbl[4] = '{x: -10, hold: 0, exp_y:  10};
    tbl[5] = '{x:  -9, hold: 0, exp_y: -11};
    tbl[6] = '{x:  -8, hold: 4, exp_y: -40};
    tbl[7] = '{x:  -7, hold: 0, exp_y: -36};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      do_sample(tbl[i].x, tbl[i].hold, 1'b0, 0, 0, 1'b0, y);
      check($sformatf("table_%0d", i), y, tbl[i].exp_y);
      if (i >= 1 && i <= 3) check("accept_gap", gap, 5);
    end

    // coefficient write in IDLE, then impulse
    write_coef(1, 5);
    repeat (3) do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    do_sample(1, 0, 1'b0, 0, 0, 1'b0, y);
    check("wr_impulse_0", y, -1);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    check("wr_impulse_1", y, 5);

    // write during MAC and write to addr 3 are both ignored
    do_sample(0, 0, 1'b0, 0, 0, 1'b1, y);
    write_coef(3, 100);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    do_sample(1, 0, 1'b0, 0, 0, 1'b0, y);
    check("ign_impulse_0", y, -1);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    check("ign_impulse_1", y, 5);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    check("ign_impulse_2", y, 3);

    // simultaneous write and accept: the new coefficient applies immediately
    do_sample(1, 0, 1'b1, 0, 9, 1'b0, y);
    check("simul_wr", y, 9);

    // extremes
    write_coef(0, -128); write_coef(1, -128); write_coef(2, -128);
    repeat (3) do_sample(-128, 0, 1'b0, 0, 0, 1'b0, y);
    check("extreme", y, 49152);

    for (int i = 0; i < 40; i++) begin
      x     = int'($urandom_range(0, 255)) - 128;
      hold  = int'($urandom_range(0, 2));
      we    = ($urandom_range(0, 3) == 0);
      waddr = int'($urandom_range(0, 4));
      wdata = int'($urandom_range(0, 255)) - 128;
      mw    = ($urandom_range(0, 5) == 0);
      do_sample(x, hold, we, waddr, wdata, mw, y);
    end

    // reset in the middle of a computation
    do_sample(3, 0, 1'b0, 0, 0, 1'b0, y);
    in_valid = 1'b1; in_data = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #2;
    check("async_rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_out_data", int'(out_data), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    do_sample(1, 0, 1'b0, 0, 0, 1'b0, y);
    check("after_rst_0", y, -1);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    check("after_rst_1", y, 2);
    do_sample(0, 0, 1'b0, 0, 0, 1'b0, y);
    check("after_rst_2", y, 3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
